// File: rtl/vga_text_render.sv
// vga_text_render: 80x30 text-mode pixel generator (8x16 font, 640x480).
// Ports: pclk/reset (sync, active-high); h_addr/v_addr/valid from the timing
//   controller; char_addr/char_data to char RAM (1-cycle read latency);
//   font_addr/font_data to font ROM (1-cycle read latency); vga_data RGB444 out.
// Optional: define VGA_TEXT_CURSOR_EN to add cursor_x/cursor_y and a blinking
//   underline cursor (cell rows 14-15 inverted, blink period from BLINK_FRAMES).
module vga_text_render #(
    parameter logic [11:0] FG_COLOR     = 12'hFFF,
    parameter logic [11:0] BG_COLOR     = 12'h000,
    parameter int          BLINK_FRAMES = 30,
    parameter int          COLS         = 80
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic [9:0]  h_addr,
    input  logic [9:0]  v_addr,
    input  logic        valid,
    output logic [11:0] char_addr,
    input  logic [7:0]  char_data,
    output logic [11:0] font_addr,
    input  logic [7:0]  font_data,
`ifdef VGA_TEXT_CURSOR_EN
    input  logic [6:0]  cursor_x,
    input  logic [4:0]  cursor_y,
`endif
    output logic [11:0] vga_data
);

    logic [6:0] col;
    logic [4:0] row;
    logic       in_range;

    assign col      = h_addr[9:3];
    assign row      = v_addr[8:4];
    assign in_range = (h_addr < 10'(COLS * 8)) && (v_addr < 10'd480);

    // Pipeline side-band registers, one set per stage
    logic [2:0] gx1, gx2, gx3;
    logic [3:0] gy1, gy2;
    logic       v1, v2, v3;
    logic       pix;

`ifdef VGA_TEXT_CURSOR_EN
    logic [5:0] blink_cnt;
    logic       blink_on;
    logic       frame_tick;
    logic       hit_in;
    logic       hit1, hit2, hit3;

    assign frame_tick = valid && (h_addr == 10'd0) && (v_addr == 10'd0);

    // Underline: only cell rows 14 and 15 (gy[3:1] == 3'b111)
    assign hit_in = blink_on && (col == cursor_x) && (row == cursor_y)
                    && (v_addr[3:1] == 3'b111);

    always_ff @(posedge pclk) begin
        if (reset) begin
            blink_cnt <= 6'd0;
            blink_on  <= 1'b1;
        end else if (frame_tick) begin
            if (blink_cnt == 6'(BLINK_FRAMES - 1)) begin
                blink_cnt <= 6'd0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + 6'd1;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            hit1 <= 1'b0;
            hit2 <= 1'b0;
            hit3 <= 1'b0;
        end else begin
            hit1 <= hit_in;
            hit2 <= hit1;
            hit3 <= hit2;
        end
    end
`endif

    // row*80 + col as shift-add; 12 bits covers every input pattern
    always_ff @(posedge pclk) begin
        if (reset) begin
            char_addr <= 12'd0;
            gx1       <= 3'd0;
            gy1       <= 4'd0;
            v1        <= 1'b0;
            gx2       <= 3'd0;
            gy2       <= 4'd0;
            v2        <= 1'b0;
            gx3       <= 3'd0;
            v3        <= 1'b0;
        end else begin
            char_addr <= ({7'd0, row} << 6) + ({7'd0, row} << 4)
                         + {5'd0, col};
            gx1       <= h_addr[2:0];
            gy1       <= v_addr[3:0];
            v1        <= valid && in_range;
            gx2       <= gx1;
            gy2       <= gy1;
            v2        <= v1;
            gx3       <= gx2;
            v3        <= v2;
        end
    end

    assign font_addr = {char_data, gy2};

    // Bit 7 is the leftmost pixel of the glyph row
    always_comb begin
        pix = font_data[3'd7 - gx3];
`ifdef VGA_TEXT_CURSOR_EN
        pix = pix ^ hit3;
`endif
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            vga_data <= 12'h000;
        end else if (v3) begin
            vga_data <= pix ? FG_COLOR : BG_COLOR;
        end else begin
            vga_data <= 12'h000;
        end
    end

endmodule

// File: tb/tb_vga_text_render.sv
// tb_vga_text_render: directed bench for vga_text_render with small
// behavioural char RAM / font ROM models and a 4-edge latency queue.
module tb_vga_text_render;

    localparam logic [11:0] FG = 12'hA5C;
    localparam logic [11:0] BG = 12'h3C1;

    logic        pclk = 1'b0;
    logic        reset;
    logic [9:0]  h_addr;
    logic [9:0]  v_addr;
    logic        valid;
    logic [11:0] char_addr;
    logic [7:0]  char_data;
    logic [11:0] font_addr;
    logic [7:0]  font_data;
    logic [11:0] vga_data;
`ifdef VGA_TEXT_CURSOR_EN
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    logic [11:0] eq[$];
    string       tq[$];

    vga_text_render #(
        .FG_COLOR(FG),
        .BG_COLOR(BG),
        .BLINK_FRAMES(2),
        .COLS(80)
    ) dut (
        .pclk(pclk),
        .reset(reset),
        .h_addr(h_addr),
        .v_addr(v_addr),
        .valid(valid),
        .char_addr(char_addr),
        .char_data(char_data),
        .font_addr(font_addr),
        .font_data(font_data),
`ifdef VGA_TEXT_CURSOR_EN
        .cursor_x(cursor_x),
        .cursor_y(cursor_y),
`endif
        .vga_data(vga_data)
    );

    always #20 pclk = ~pclk;

    function automatic logic [7:0] cram(input logic [11:0] a);
        if (a < 12'd80)          return 8'h41;
        else if (a == 12'd255)   return 8'hFF;
        else if (a == 12'd82)    return 8'h52;
        else if (a == 12'd2399)  return 8'h5F;
        else                     return 8'h00;
    endfunction

    function automatic logic [7:0] rom(input logic [11:0] fa);
        logic [7:0] c;
        c = fa[11:4];
        if (c == 8'h00)      return 8'h00;
        else if (c == 8'h41) return 8'h81;
        else                 return c ^ {fa[3:0], 4'h0};
    endfunction

    always @(posedge pclk) begin
        char_data <= cram(char_addr);
        font_data <= rom(font_addr);
    end

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [11:0] got,
                       input logic [11:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic px(input int h, input int v, input logic val,
                      input logic [11:0] e, input string tag);
        h_addr = 10'(h);
        v_addr = 10'(v);
        valid  = val;
        eq.push_back(e);
        tq.push_back(tag);
        step();
        if (eq.size() == 4) chk(tq.pop_front(), vga_data, eq.pop_front());
    endtask

    task automatic bubble();
        eq.delete();
        tq.delete();
        repeat (3) begin
            eq.push_back(12'h000);
            tq.push_back("bubble");
        end
    endtask

    initial begin
        reset  = 1'b1;
        valid  = 1'b1;
        h_addr = 10'd0;
        v_addr = 10'd0;
`ifdef VGA_TEXT_CURSOR_EN
        cursor_x = 7'd5;
        cursor_y = 5'd2;
`endif
        repeat (3) begin
            step();
            chk("rst_vga", vga_data, 12'h000);
            chk("rst_caddr", char_addr, 12'd0);
        end
        reset = 1'b0;

        h_addr = 10'd637;
        v_addr = 10'd479;
        step();
        chk("caddr_max", char_addr, 12'd2399);
        h_addr = 10'd19;
        v_addr = 10'd21;
        step();
        chk("faddr_max", font_addr, 12'h5FF);
        chk("caddr_r1c2", char_addr, 12'd82);
        step();
        chk("faddr_r1c2", font_addr, 12'h525);

        eq.delete();
        tq.delete();
        for (int i = 0; i < 8; i++)
            px(i, 0, 1'b1, (i == 0 || i == 7) ? FG : BG, "row0");
        repeat (3) px(0, 0, 1'b0, 12'h000, "flush");

        for (int i = 0; i < 8; i++)
            px(120 + i, 48, (i % 2 == 0), (i % 2 == 0) ? FG : 12'h000,
               "valid_alt");
        px(700, 48, 1'b1, 12'h000, "h_range");
        px(100, 480, 1'b1, 12'h000, "v_range");
        px(16, 21, 1'b1, BG, "r1_gx0");
        px(17, 21, 1'b1, BG, "r1_gx1");
        px(22, 21, 1'b1, FG, "r1_gx6");
        px(23, 21, 1'b1, BG, "r1_gx7");
        repeat (3) px(0, 0, 1'b0, 12'h000, "flush");

        for (int i = 0; i < 3; i++)
            px(i, 0, 1'b1, (i == 0) ? FG : BG, "pre_rst");
        h_addr = 10'd4;
        v_addr = 10'd0;
        valid  = 1'b1;
        reset  = 1'b1;
        step();
        chk("midrst_vga", vga_data, 12'h000);
        chk("midrst_caddr", char_addr, 12'd0);
        step();
        chk("midrst_vga2", vga_data, 12'h000);
        reset = 1'b0;
        bubble();
        for (int i = 0; i < 8; i++)
            px(i, 0, 1'b1, (i == 0 || i == 7) ? FG : BG, "post_rst");
        repeat (3) px(0, 0, 1'b0, 12'h000, "flush");

`ifdef VGA_TEXT_CURSOR_EN
        reset = 1'b1;
        step();
        reset = 1'b0;
        bubble();
        for (int f = 0; f < 5; f++) begin
            if (f > 0) px(0, 0, 1'b1, FG, "tick_px");
            px(40, 46, 1'b1, (f == 2 || f == 3) ? BG : FG, "cur_l");
            px(47, 46, 1'b1, (f == 2 || f == 3) ? BG : FG, "cur_r");
            px(40, 47, 1'b1, (f == 2 || f == 3) ? BG : FG, "cur_gy15");
            px(40, 45, 1'b1, BG, "cur_gy13");
            px(48, 46, 1'b1, BG, "cur_col6");
        end
        cursor_x = 7'd80;
        px(40, 46, 1'b1, BG, "cur_x80");
        px(0, 0, 1'b1, FG, "tick_px");
        px(40, 46, 1'b1, BG, "cur_x80b");
        repeat (3) px(0, 0, 1'b0, 12'h000, "flush");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
